mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter OP_CODE_LEN, default 6, opcode width.
REQ-002 SHALL have parameter EXE_CMD_LEN, default 4, EXE command width.
REQ-003 SHALL have parameter WORD_LEN, default 32, operand and HI/LO width.
REQ-004 SHALL have parameter MUL_CYCLES, default 4, multiply latency; legal range is 2..64.
REQ-005 SHALL have parameter DIV_CYCLES, default WORD_LEN, divide latency; legal range is 2..64.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port opCode, input, OP_CODE_LEN bits: ID-stage opcode.
REQ-009 SHALL have port valid_in, input, 1 bit: ID holds a real instruction.
REQ-010 SHALL have port hazard_detected, input, 1 bit: data hazard in ID.
REQ-011 SHALL have port flush, input, 1 bit: kill the ID instruction (branch taken).
REQ-012 SHALL have ports op_a and op_b, input, WORD_LEN bits each: rs and rt values for MULT/DIV.
REQ-013 SHALL have outputs branchEn, Branch_command[1:0], Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN and MEM_W_EN, 1 bit each except Branch_command, registered as the ID/EXE control bundle.
REQ-014 SHALL have output EXE_CMD, EXE_CMD_LEN bits: registered EXE command.
REQ-015 SHALL have output stall_out, 1 bit: upstream holds PC and IF/ID this cycle.
REQ-016 SHALL have output md_busy, 1 bit: a multiply or divide is in flight.
REQ-017 SHALL have output hilo_data, WORD_LEN bits: registered HI or LO for MFHI/MFLO.

Function
REQ-018 SHALL decode combinationally every opcode in the shared table to the bundle; unknown opcodes SHALL decode to all-zero.
REQ-019 SHALL register the bundle on each edge (1-cycle latency, ID to EXE).
REQ-020 SHALL register an all-zero bubble when any of these holds: valid_in=0, hazard_detected=1, flush=1, or stall_out=1.
REQ-021 SHALL run a state machine IDLE -> MUL or DIV -> IDLE.
- IDLE: a MULT or DIV is issued when it is in ID, not bubbled, and the state is IDLE.
- Issue edge: op_a and op_b are captured, the state enters MUL or DIV, and the counter loads N-1, where N is MUL_CYCLES or DIV_CYCLES.
REQ-022 SHALL hold md_busy=1 for exactly N cycles after the issue edge.
- Completion: on the edge that ends the N-th cycle, HI and LO update, the state returns to IDLE, and md_busy falls.
REQ-023 SHALL drive stall_out=md_busy AND valid_in AND the ID opcode being MULT, DIV, MFHI or MFLO; all other opcodes SHALL proceed while busy.
REQ-024 SHALL compute MULT as a signed 2*WORD_LEN-bit product: HI = upper half, LO = lower half.
REQ-025 SHALL compute DIV as signed division truncating toward zero: LO = quotient, HI = remainder with the sign of the dividend.
REQ-026 SHALL handle divide by zero as: LO = all-ones, HI = dividend.
REQ-027 SHALL handle DIV of the most-negative value by -1 as: LO = most-negative value, HI = 0.
REQ-028 SHALL register hilo_data = HI for MFHI and LO for MFLO, with WB_EN=1 and EXE_CMD = EXE_MFHI or EXE_MFLO.
REQ-029 SHALL let an MFHI/MFLO in ID on the completion cycle stall that cycle, then read the new value on the next edge.
REQ-030 SHALL NOT abort an in-flight operation on flush or hazard_detected; these inputs affect only the ID instruction.
REQ-031 SHALL, for a back-to-back MULT following a MULT, stall until IDLE and issue on the first IDLE edge.

Reset
REQ-032 SHALL, on rst=1 (asynchronous), clear all of the following immediately, including mid-operation:
- every bundle output to 0 and hilo_data to 0;
- HI and LO to 0;
- the state to IDLE and the counter to 0;
- md_busy and stall_out to 0.
REQ-033 SHALL, on rst release, accept an instruction on the first rising edge.

Structure
REQ-034 SHALL take from shared defines.v:
- opcodes, including new OP_DIV;
- EXE_* codes, including new EXE_DIV;
- COND_* codes, OP_CODE_LEN, EXE_CMD_LEN and WORD_LEN.
REQ-035 SHALL place the iterative multiply/divide datapath, counter and HI/LO in one sub-module md_unit; mc_controller SHALL hold decode, bundle register and stall logic.

Verification
REQ-036 SHALL verify: reset pulse asserted mid-MULT -> outputs 0 and md_busy=0 at once; MFLO after release -> hilo_data=0.
REQ-037 SHALL verify: MULT with op_a=-3, op_b=7, MUL_CYCLES=4 -> md_busy high exactly 4 cycles; HI=FFFFFFFF, LO=FFFFFFEB; a following MFLO -> hilo_data=FFFFFFEB.
REQ-038 SHALL verify: DIV 17/-5 -> LO=FFFFFFFD, HI=2; DIV 9/0 -> LO=FFFFFFFF, HI=9; DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
REQ-039 SHALL verify: MFHI issued on the cycle after a MULT -> stall_out=1 until completion, then hilo_data equals the new HI; ADD issued while busy -> no stall, WB_EN=1 next cycle.
REQ-040 SHALL verify: ADD with hazard_detected=1 -> all-zero bundle; ADD with flush=1 -> bubble; flush during DIV -> HI/LO still update at cycle DIV_CYCLES.
REQ-041 SHALL verify: MULT, MULT back-to-back -> second issues on the completion cycle's following edge; total busy = 2*MUL_CYCLES cycles plus 1 gap cycle.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared opcode, EXE-command and branch-condition table for the ID/EXE controller,
// plus the control-bundle layout and its combinational decoder.
package mc_controller_pkg;

    localparam int DEF_OP_CODE_LEN = 6;
    localparam int DEF_EXE_CMD_LEN = 4;
    localparam int DEF_WORD_LEN    = 32;
    localparam int MD_CNT_W        = 6;

    localparam logic [DEF_OP_CODE_LEN-1:0] OP_NOP  = 6'd0;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_ADD  = 6'd1;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SUB  = 6'd3;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_AND  = 6'd5;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_OR   = 6'd6;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_NOR  = 6'd7;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_XOR  = 6'd8;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SLA  = 6'd9;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SLL  = 6'd10;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SRA  = 6'd11;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SRL  = 6'd12;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_MULT = 6'd13;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_DIV  = 6'd14;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_MFHI = 6'd15;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_MFLO = 6'd16;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_ADDI = 6'd32;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_SUBI = 6'd33;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_LD   = 6'd36;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_ST   = 6'd37;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_BEZ  = 6'd40;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_BNE  = 6'd41;
    localparam logic [DEF_OP_CODE_LEN-1:0] OP_JMP  = 6'd42;

    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_ADD          = 4'd0;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_SUB          = 4'd2;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_AND          = 4'd4;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_OR           = 4'd5;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_NOR          = 4'd6;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_XOR          = 4'd7;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_SLA          = 4'd8;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_SRA          = 4'd9;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_SRL          = 4'd10;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_MULT         = 4'd11;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_DIV          = 4'd12;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_MFHI         = 4'd13;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_MFLO         = 4'd14;
    localparam logic [DEF_EXE_CMD_LEN-1:0] EXE_NO_OPERATION = 4'd15;

    localparam logic [1:0] COND_JUMP = 2'd1;
    localparam logic [1:0] COND_BEZ  = 2'd2;
    localparam logic [1:0] COND_BNE  = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    typedef struct packed {
        logic                       branch_en;
        logic [1:0]                 branch_command;
        logic                       is_imm;
        logic                       st_or_bne;
        logic                       wb_en;
        logic                       mem_r_en;
        logic                       mem_w_en;
        logic [DEF_EXE_CMD_LEN-1:0] exe_cmd;
    } ctrl_bundle_t;

    function automatic ctrl_bundle_t decode_op(input logic [DEF_OP_CODE_LEN-1:0] op);
        ctrl_bundle_t c;
        c = '0;
        case (op)
            OP_ADD:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_ADD; end
            OP_SUB:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SUB; end
            OP_AND:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_AND; end
            OP_OR:   begin c.wb_en = 1'b1; c.exe_cmd = EXE_OR;  end
            OP_NOR:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_NOR; end
            OP_XOR:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_XOR; end
            OP_SLA, OP_SLL: begin c.wb_en = 1'b1; c.exe_cmd = EXE_SLA; end
            OP_SRA:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SRA; end
            OP_SRL:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SRL; end
            OP_MULT: c.exe_cmd = EXE_MULT;
            OP_DIV:  c.exe_cmd = EXE_DIV;
            OP_MFHI: begin c.wb_en = 1'b1; c.exe_cmd = EXE_MFHI; end
            OP_MFLO: begin c.wb_en = 1'b1; c.exe_cmd = EXE_MFLO; end
            OP_ADDI: begin c.wb_en = 1'b1; c.is_imm = 1'b1; c.exe_cmd = EXE_ADD; end
            OP_SUBI: begin c.wb_en = 1'b1; c.is_imm = 1'b1; c.exe_cmd = EXE_SUB; end
            OP_LD: begin
                c.wb_en = 1'b1; c.mem_r_en = 1'b1; c.is_imm = 1'b1; c.exe_cmd = EXE_ADD;
            end
            OP_ST: begin
                c.mem_w_en = 1'b1; c.is_imm = 1'b1; c.st_or_bne = 1'b1; c.exe_cmd = EXE_ADD;
            end
            OP_BEZ: begin
                c.branch_en = 1'b1; c.branch_command = COND_BEZ; c.is_imm = 1'b1;
                c.exe_cmd = EXE_NO_OPERATION;
            end
            OP_BNE: begin
                c.branch_en = 1'b1; c.branch_command = COND_BNE; c.is_imm = 1'b1;
                c.st_or_bne = 1'b1; c.exe_cmd = EXE_NO_OPERATION;
            end
            OP_JMP: begin
                c.branch_en = 1'b1; c.branch_command = COND_JUMP; c.is_imm = 1'b1;
                c.exe_cmd = EXE_NO_OPERATION;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multicycle signed multiply/divide unit: captures operands on issue, counts down the
// configured latency, then commits the result into HI/LO.
module md_unit
    import mc_controller_pkg::*;
#(
    parameter int WORD_LEN   = DEF_WORD_LEN,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = WORD_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_mul,
    input  logic                issue_div,
    input  logic [WORD_LEN-1:0] op_a,
    input  logic [WORD_LEN-1:0] op_b,
    output md_state_t           state,
    output logic [WORD_LEN-1:0] hi,
    output logic [WORD_LEN-1:0] lo
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);
    localparam logic [WORD_LEN-1:0] MOST_NEG = {1'b1, {(WORD_LEN-1){1'b0}}};

    logic [MD_CNT_W-1:0]          cnt;
    logic signed [WORD_LEN-1:0]   a_q;
    logic signed [WORD_LEN-1:0]   b_q;
    logic [2*WORD_LEN-1:0]        prod;
    logic [WORD_LEN-1:0]          quo;
    logic [WORD_LEN-1:0]          rem;

    // The arithmetic settles from the captured operands over the whole countdown,
    // so it is a multicycle path into HI/LO.
    always_comb begin
        prod = {{WORD_LEN{a_q[WORD_LEN-1]}}, a_q} * {{WORD_LEN{b_q[WORD_LEN-1]}}, b_q};
        quo  = '0;
        rem  = '0;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else if (a_q == MOST_NEG && b_q == '1) begin
            quo = MOST_NEG;
            rem = '0;
        end else begin
            quo = a_q / b_q;
            rem = a_q % b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (issue_mul) begin
                        state <= MD_MUL;
                        cnt   <= MUL_LOAD;
                        a_q   <= op_a;
                        b_q   <= op_b;
                    end else if (issue_div) begin
                        state <= MD_DIV;
                        cnt   <= DIV_LOAD;
                        a_q   <= op_a;
                        b_q   <= op_b;
                    end
                end
                MD_MUL: begin
                    if (cnt == '0) begin
                        hi    <= prod[2*WORD_LEN-1:WORD_LEN];
                        lo    <= prod[WORD_LEN-1:0];
                        state <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_DIV: begin
                    if (cnt == '0) begin
                        hi    <= rem;
                        lo    <= quo;
                        state <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mc_controller.sv
// ID-stage controller: decodes the opcode into the registered ID/EXE control bundle,
// bubbles it on hazards, and stalls multiply/divide/HI-LO traffic while md_unit is busy.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int OP_CODE_LEN = DEF_OP_CODE_LEN,
    parameter int EXE_CMD_LEN = DEF_EXE_CMD_LEN,
    parameter int WORD_LEN    = DEF_WORD_LEN,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = WORD_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_CODE_LEN-1:0] opCode,
    input  logic                   valid_in,
    input  logic                   hazard_detected,
    input  logic                   flush,
    input  logic [WORD_LEN-1:0]    op_a,
    input  logic [WORD_LEN-1:0]    op_b,
    output logic                   branchEn,
    output logic [1:0]             Branch_command,
    output logic                   Is_Imm,
    output logic                   ST_or_BNE,
    output logic                   WB_EN,
    output logic                   MEM_R_EN,
    output logic                   MEM_W_EN,
    output logic [EXE_CMD_LEN-1:0] EXE_CMD,
    output logic                   stall_out,
    output logic                   md_busy,
    output logic [WORD_LEN-1:0]    hilo_data
);

    ctrl_bundle_t        dec;
    ctrl_bundle_t        bundle_q;
    md_state_t           md_state;
    logic [WORD_LEN-1:0] hi;
    logic [WORD_LEN-1:0] lo;
    logic [WORD_LEN-1:0] hilo_q;
    logic                is_mult;
    logic                is_div;
    logic                is_mfhi;
    logic                is_mflo;
    logic                bubble;

    assign dec     = decode_op(opCode);
    assign is_mult = (opCode == OP_MULT);
    assign is_div  = (opCode == OP_DIV);
    assign is_mfhi = (opCode == OP_MFHI);
    assign is_mflo = (opCode == OP_MFLO);

    // Handshake: the ID instruction is consumed on a rising edge when valid_in=1 and
    // stall_out=0; with stall_out=1 upstream must hold opCode/op_a/op_b unchanged.
    assign md_busy   = (md_state != MD_IDLE);
    assign stall_out = md_busy && valid_in && (is_mult || is_div || is_mfhi || is_mflo);
    assign bubble    = !valid_in || hazard_detected || flush || stall_out;

    md_unit #(
        .WORD_LEN   (WORD_LEN),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_unit (
        .clk       (clk),
        .rst       (rst),
        .issue_mul (!bubble && is_mult),
        .issue_div (!bubble && is_div),
        .op_a      (op_a),
        .op_b      (op_b),
        .state     (md_state),
        .hi        (hi),
        .lo        (lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            hilo_q   <= '0;
        end else if (bubble) begin
            bundle_q <= '0;
            hilo_q   <= '0;
        end else begin
            bundle_q <= dec;
            hilo_q   <= is_mfhi ? hi : (is_mflo ? lo : '0);
        end
    end

    assign branchEn       = bundle_q.branch_en;
    assign Branch_command = bundle_q.branch_command;
    assign Is_Imm         = bundle_q.is_imm;
    assign ST_or_BNE      = bundle_q.st_or_bne;
    assign WB_EN          = bundle_q.wb_en;
    assign MEM_R_EN       = bundle_q.mem_r_en;
    assign MEM_W_EN       = bundle_q.mem_w_en;
    assign EXE_CMD        = EXE_CMD_LEN'(bundle_q.exe_cmd);
    assign hilo_data      = hilo_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a driver pushes the hand-computed observation for
// every cycle into a queue, and a monitor compares it against the DUT after each edge.
module tb_mc_controller;
    import mc_controller_pkg::*;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    // Bundle packing: {branchEn, Branch_command[1:0], Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0]}
    localparam logic [11:0] B_NONE = 12'h000;
    localparam logic [11:0] B_ADD  = 12'h040;
    localparam logic [11:0] B_MULT = 12'h00B;
    localparam logic [11:0] B_DIV  = 12'h00C;
    localparam logic [11:0] B_MFHI = 12'h04D;
    localparam logic [11:0] B_MFLO = 12'h04E;
    localparam logic [11:0] B_LD   = 12'h160;
    localparam logic [11:0] B_ST   = 12'h190;
    localparam logic [11:0] B_BNE  = 12'hF8F;

    logic        clk;
    logic        rst;
    logic [5:0]  opCode;
    logic        valid_in;
    logic        hazard_detected;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        branchEn;
    logic [1:0]  Branch_command;
    logic        Is_Imm;
    logic        ST_or_BNE;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [3:0]  EXE_CMD;
    logic        stall_out;
    logic        md_busy;
    logic [31:0] hilo_data;

    logic [45:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    mc_controller #(
        .OP_CODE_LEN (6),
        .EXE_CMD_LEN (4),
        .WORD_LEN    (32),
        .MUL_CYCLES  (MUL_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .opCode          (opCode),
        .valid_in        (valid_in),
        .hazard_detected (hazard_detected),
        .flush           (flush),
        .op_a            (op_a),
        .op_b            (op_b),
        .branchEn        (branchEn),
        .Branch_command  (Branch_command),
        .Is_Imm          (Is_Imm),
        .ST_or_BNE       (ST_or_BNE),
        .WB_EN           (WB_EN),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN),
        .EXE_CMD         (EXE_CMD),
        .stall_out       (stall_out),
        .md_busy         (md_busy),
        .hilo_data       (hilo_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Observation vector: {stall_out, md_busy, bundle[11:0], hilo_data[31:0]}
    function automatic logic [45:0] cur_obs(input logic st);
        return {st, md_busy, branchEn, Branch_command, Is_Imm, ST_or_BNE, WB_EN,
                MEM_R_EN, MEM_W_EN, EXE_CMD, hilo_data};
    endfunction

    task automatic check_now(input string nm, input logic [45:0] act, input logic [45:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: stall_out is sampled mid-cycle, registered outputs after the edge
    initial begin : monitor
        logic        st;
        logic [45:0] exp;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                st = stall_out;
                @(posedge clk);
                #2;
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                check_now(nm, cur_obs(st), exp);
            end
        end
    end

    // Driver tasks
    task automatic step(input logic [5:0] op, input logic v, input logic h, input logic f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic e_stall, input logic e_busy, input logic [11:0] e_bundle,
                        input logic [31:0] e_hilo, input string nm);
        opCode = op; valid_in = v; hazard_detected = h; flush = f; op_a = a; op_b = b;
        exp_q.push_back({e_stall, e_busy, e_bundle, e_hilo});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e_busy, input string nm);
        step(OP_NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, e_busy, B_NONE, 32'h0, nm);
    endtask

    task automatic read_hl(input logic [5:0] op, input logic [31:0] e_hilo, input string nm);
        step(op, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,
             (op == OP_MFHI) ? B_MFHI : B_MFLO, e_hilo, nm);
    endtask

    // Issue, ride out n-1 busy cycles (optionally with flushed ADDs in ID), then completion
    task automatic md_run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic flush_mode, input string nm);
        step(op, 1'b1, 1'b0, 1'b0, a, b, 1'b0, 1'b1, (op == OP_MULT) ? B_MULT : B_DIV, 32'h0,
             {nm, "_issue"});
        for (int i = 0; i < n - 1; i++) begin
            if (flush_mode)
                step(OP_ADD, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, B_NONE, 32'h0,
                     {nm, "_flushed_add"});
            else
                idle(1'b1, {nm, "_busy"});
        end
        idle(1'b0, {nm, "_done"});
    endtask

    initial begin : stimulus
        rst = 1'b1;
        opCode = OP_NOP; valid_in = 1'b0; hazard_detected = 1'b0; flush = 1'b0;
        op_a = 32'h0; op_b = 32'h0;
        #3;
        check_now("reset_state", cur_obs(stall_out), 46'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // MULT -3 * 7, busy exactly MUL_N cycles, then read LO/HI
        md_run(OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_N, 1'b0, "mult_m3x7");
        read_hl(OP_MFLO, 32'hFFFF_FFEB, "mflo_m3x7");
        read_hl(OP_MFHI, 32'hFFFF_FFFF, "mfhi_m3x7");

        // MFHI right behind a MULT stalls through completion, then reads the new HI
        step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b1, B_MULT, 32'h0, "mult_big_issue");
        for (int i = 0; i < MUL_N - 1; i++)
            step(OP_MFHI, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, B_NONE, 32'h0, "mfhi_stalled");
        step(OP_MFHI, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, B_NONE, 32'h0, "mfhi_stall_completion");
        read_hl(OP_MFHI, 32'h0000_0003, "mfhi_new_hi");

        // Non-MD traffic proceeds while busy; hazard and flush bubble the bundle
        step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0, 1'b1, B_MULT, 32'h0, "mult_2x3_issue");
        step(OP_ADD, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, B_ADD, 32'h0, "add_while_busy");
        step(OP_SUB, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, B_NONE, 32'h0, "sub_hazard_bubble");
        step(OP_ADD, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, B_NONE, 32'h0, "add_flush_bubble");
        step(OP_LD, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, B_LD, 32'h0, "ld_completion_cycle");
        read_hl(OP_MFLO, 32'h0000_0006, "mflo_2x3");
        step(OP_ST, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, B_ST, 32'h0, "st_decode");
        step(OP_BNE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, B_BNE, 32'h0, "bne_decode");
        step(6'd63, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, B_NONE, 32'h0, "unknown_op_zero");
        step(OP_ADD, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, B_NONE, 32'h0, "add_not_valid");

        // Signed division corner cases
        md_run(OP_DIV, 32'd17, 32'hFFFF_FFFB, DIV_N, 1'b0, "div_17_m5");
        read_hl(OP_MFLO, 32'hFFFF_FFFD, "div_17_m5_lo");
        read_hl(OP_MFHI, 32'h0000_0002, "div_17_m5_hi");
        md_run(OP_DIV, 32'hFFFF_FFEF, 32'd5, DIV_N, 1'b1, "div_m17_5_flush");
        read_hl(OP_MFLO, 32'hFFFF_FFFD, "div_m17_5_lo");
        read_hl(OP_MFHI, 32'hFFFF_FFFE, "div_m17_5_hi");
        md_run(OP_DIV, 32'd9, 32'h0, DIV_N, 1'b0, "div_9_0");
        read_hl(OP_MFLO, 32'hFFFF_FFFF, "div_9_0_lo");
        read_hl(OP_MFHI, 32'h0000_0009, "div_9_0_hi");
        md_run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0, "div_min_m1");
        read_hl(OP_MFLO, 32'h8000_0000, "div_min_m1_lo");
        read_hl(OP_MFHI, 32'h0000_0000, "div_min_m1_hi");

        // Back-to-back MULT: second waits through completion, issues after one idle gap
        step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'd4, 32'd5, 1'b0, 1'b1, B_MULT, 32'h0, "b2b_first_issue");
        for (int i = 0; i < MUL_N - 1; i++)
            step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 1'b1, 1'b1, B_NONE, 32'h0, "b2b_second_stalled");
        step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 1'b1, 1'b0, B_NONE, 32'h0, "b2b_completion_stall");
        md_run(OP_MULT, 32'd6, 32'd7, MUL_N, 1'b0, "b2b_second");
        read_hl(OP_MFLO, 32'h0000_002A, "b2b_mflo");
        read_hl(OP_MFHI, 32'h0000_0000, "b2b_mfhi");

        // Asynchronous reset in the middle of a MULT
        step(OP_MULT, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, B_MULT, 32'h0, "rst_mult_issue");
        opCode = OP_MFLO; valid_in = 1'b1; hazard_detected = 1'b0; flush = 1'b0;
        #3;
        check_now("pre_rst_stall", cur_obs(stall_out), {1'b1, 1'b1, B_MULT, 32'h0});
        rst = 1'b1;
        #1;
        check_now("rst_mid_mult", cur_obs(stall_out), 46'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_now("rst_hold", cur_obs(stall_out), 46'h0);
        rst = 1'b0;
        read_hl(OP_MFLO, 32'h0000_0000, "mflo_after_rst");
        read_hl(OP_MFHI, 32'h0000_0000, "mfhi_after_rst");
        for (int i = 0; i < MUL_N + 1; i++)
            idle(1'b0, "no_resume_after_rst");
        read_hl(OP_MFLO, 32'h0000_0000, "mflo_still_zero");

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
